access_arbiter: RTL and testbench

ACCESS_ARBITER -- requirements
Module: access_arbiter

---
 rtl/access_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_access_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : access_arbiter
// Brief    : Two-requester door access arbiter. Round-robin grant, code check,
//            timed door enable, and lockout after repeated wrong codes.
// Revision : 1.0 - initial release
// ============================================================================
module access_arbiter #(
  parameter logic [3:0] PASSWORD    = 4'b1010,
  parameter int         OPEN_CYCLES = 8,
  parameter int         LOCK_CYCLES = 16,
  parameter int         MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] confirm,
  input  logic [3:0] pass_l,
  input  logic [3:0] pass_r,
  output logic [1:0] grant,
  output logic       en_left,
  output logic       en_right,
  output logic [3:0] dout,
  output logic       locked,
  output logic [1:0] fail_cnt,
  output logic [2:0] state
);

  // Timer must hold the larger of the two reload values.
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    MAX_F     = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    CHECK = 3'd2,
    OPEN  = 3'd3,
    DENY  = 3'd4,
    LOCK  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_d;
  logic          en_left_d, en_right_d, locked_d;
  logic [3:0]    dout_d;
  logic [1:0]    fail_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    code_q, code_d;
  // ptr = 1 means the right requester was served last, so left wins a tie.
  logic          ptr_q, ptr_d;
  logic          gnt_req, gnt_cfm;

  assign state   = state_q;
  assign gnt_req = |(req & grant);
  assign gnt_cfm = |(confirm & grant);

  // State and all registered outputs; reset acts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant    <= 2'b00;
      en_left  <= 1'b0;
      en_right <= 1'b0;
      dout     <= 4'b0000;
      locked   <= 1'b0;
      fail_cnt <= 2'd0;
      timer_q  <= '0;
      code_q   <= 4'b0000;
      ptr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      en_left  <= en_left_d;
      en_right <= en_right_d;
      dout     <= dout_d;
      locked   <= locked_d;
      fail_cnt <= fail_cnt_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      ptr_q    <= ptr_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    en_left_d  = en_left;
    en_right_d = en_right;
    dout_d     = dout;
    locked_d   = locked;
    fail_cnt_d = fail_cnt;
    timer_d    = timer_q;
    code_d     = code_q;
    ptr_d      = ptr_q;

    case (state_q)
      IDLE: begin
        grant_d    = 2'b00;
        en_left_d  = 1'b0;
        en_right_d = 1'b0;
        case (req)
          2'b01:   begin grant_d = 2'b01; state_d = GRANT; end
          2'b10:   begin grant_d = 2'b10; state_d = GRANT; end
          2'b11:   begin grant_d = ptr_q ? 2'b01 : 2'b10; state_d = GRANT; end
          default: ;
        endcase
      end

      GRANT: begin
        if (!gnt_req) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (gnt_cfm) begin
          code_d  = grant[0] ? pass_l : pass_r;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (code_q == PASSWORD) begin
          state_d    = OPEN;
          fail_cnt_d = 2'd0;
          dout_d     = code_q;
          timer_d    = OPEN_LOAD;
          en_left_d  = grant[0];
          en_right_d = grant[1];
        end else if (({1'b0, fail_cnt} + 3'd1) == MAX_F) begin
          state_d  = LOCK;
          timer_d  = LOCK_LOAD;
          grant_d  = 2'b00;
          locked_d = 1'b1;
        end else begin
          fail_cnt_d = fail_cnt + 2'd1;
          state_d    = DENY;
        end
      end

      OPEN: begin
        if (timer_q == '0) begin
          state_d    = IDLE;
          en_left_d  = 1'b0;
          en_right_d = 1'b0;
          grant_d    = 2'b00;
          ptr_d      = grant[1];
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      DENY: begin
        en_left_d  = 1'b0;
        en_right_d = 1'b0;
        if (!gnt_req) begin
          state_d = IDLE;
          grant_d = 2'b00;
          ptr_d   = grant[1];
        end
      end

      LOCK: begin
        grant_d = 2'b00;
        if (timer_q == '0) begin
          state_d    = IDLE;
          fail_cnt_d = 2'd0;
          locked_d   = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        grant_d    = 2'b00;
        en_left_d  = 1'b0;
        en_right_d = 1'b0;
        locked_d   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_access_arbiter
// Brief    : Scoreboard bench for access_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, confirm;
  logic [3:0] pass_l, pass_r;
  logic [1:0] grant;
  logic       en_left, en_right;
  logic [3:0] dout;
  logic       locked;
  logic [1:0] fail_cnt;
  logic [2:0] state;

  access_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .confirm  (confirm),
    .pass_l   (pass_l),
    .pass_r   (pass_r),
    .grant    (grant),
    .en_left  (en_left),
    .en_right (en_right),
    .dout     (dout),
    .locked   (locked),
    .fail_cnt (fail_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   illegal = 0;

  // Invariants sampled every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if ((en_left && en_right) || grant == 2'b11 || (locked && grant != 2'b00))
        illegal++;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 8'(sb.size()), 8'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; confirm = 2'b00; pass_l = 4'h0; pass_r = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Count consecutive sampled cycles a signal stays high (bounded).
  task automatic count_high(input int sel, output int n);
    logic v;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      v = (sel == 0) ? en_left : (sel == 1) ? en_right : locked;
      if (!v) break;
      n++;
      tick();
    end
  endtask

  // One wrong-code attempt from the left; leaves DUT in DENY or LOCK.
  task automatic left_wrong();
    req = 2'b01; tick();
    confirm = 2'b01; pass_l = 4'b0000; tick();
    confirm = 2'b00; tick();
  endtask

  initial begin
    int n, nl;

    // ---- reset values ----
    do_reset();
    expect_val("rst_state", 8'd0);  observe(8'(state));
    expect_val("rst_grant", 8'd0);  observe(8'(grant));
    expect_val("rst_en",    8'd0);  observe(8'({en_left, en_right}));
    expect_val("rst_dout",  8'd0);  observe(8'(dout));
    expect_val("rst_lock",  8'd0);  observe(8'(locked));
    expect_val("rst_fail",  8'd0);  observe(8'(fail_cnt));

    // ---- left correct code, req dropped mid-flow ----
    req = 2'b01;
    expect_val("s1_grant", 8'd1); expect_val("s1_st_grant", 8'd1);
    tick(); observe(8'(grant)); observe(8'(state));
    confirm = 2'b01; pass_l = 4'b1010;
    expect_val("s1_st_check", 8'd2);
    tick(); observe(8'(state));
    confirm = 2'b00; req = 2'b00;
    expect_val("s1_open_len", 8'd8); expect_val("s1_dout", 8'hA);
    expect_val("s1_st_idle", 8'd0);  expect_val("s1_grant_off", 8'd0);
    tick(); count_high(0, n);
    observe(8'(n)); observe(8'(dout)); observe(8'(state)); observe(8'(grant));

    // ---- both requesting: left first, then right by round robin ----
    do_reset();
    req = 2'b11; pass_l = 4'b1010; pass_r = 4'b1010;
    expect_val("s2_first", 8'd1);
    tick(); observe(8'(grant));
    confirm = 2'b11; tick(); tick();
    expect_val("s2_open_len", 8'd8);
    count_high(0, n); observe(8'(n));
    expect_val("s2_second", 8'd2);
    tick(); observe(8'(grant));
    req = 2'b00; confirm = 2'b00;
    expect_val("s2_abandon", 8'd0);
    tick(); observe(8'(state));

    // ---- three failures -> lockout ----
    do_reset();
    for (int i = 0; i < 2; i++) begin
      expect_val("s3_deny", 8'd4); expect_val("s3_fail", 8'(i + 1));
      expect_val("s3_hold", 8'd1);
      left_wrong(); observe(8'(state)); observe(8'(fail_cnt)); observe(8'(grant));
      req = 2'b00;
      expect_val("s3_back_idle", 8'd0);
      tick(); observe(8'(state));
    end
    expect_val("s3_lock_st", 8'd5); expect_val("s3_lock_grant", 8'd0);
    left_wrong(); observe(8'(state)); observe(8'(grant));
    req = 2'b11; confirm = 2'b11; pass_l = 4'b1010; pass_r = 4'b1010;
    expect_val("s3_lock_len", 8'd16); expect_val("s3_post_st", 8'd0);
    expect_val("s3_post_fail", 8'd0); expect_val("s3_post_en", 8'd0);
    count_high(2, n);
    observe(8'(n)); observe(8'(state)); observe(8'(fail_cnt));
    observe(8'({en_left, en_right}));
    expect_val("s3_rr_after_deny", 8'd2);
    tick(); observe(8'(grant));
    req = 2'b00; confirm = 2'b00; tick();

    // ---- two failures then success clears count ----
    do_reset();
    for (int i = 0; i < 2; i++) begin
      left_wrong(); req = 2'b00; tick();
    end
    expect_val("s4_fail2", 8'd2);
    observe(8'(fail_cnt));
    req = 2'b01; tick();
    confirm = 2'b01; pass_l = 4'b1010; tick();
    confirm = 2'b00; req = 2'b00;
    expect_val("s4_open", 8'd3); expect_val("s4_fail0", 8'd0);
    expect_val("s4_open_len", 8'd8);
    tick(); observe(8'(state)); observe(8'(fail_cnt));
    count_high(0, n); observe(8'(n));

    // ---- right granted; left inputs must have no effect ----
    do_reset();
    req = 2'b10;
    expect_val("s5_grant", 8'd2);
    tick(); observe(8'(grant));
    confirm = 2'b11; pass_r = 4'b1010; pass_l = 4'b0101; req = 2'b11;
    tick();
    confirm[0] = 1'b0; pass_l = 4'b1010; confirm[1] = 1'b0;
    tick();
    n = 0; nl = 0;
    for (int k = 0; k < 100; k++) begin
      if (!en_right) break;
      n++;
      if (en_left) nl++;
      confirm[0] = ~confirm[0];
      pass_l     = 4'($urandom);
      req[0]     = ~req[0];
      tick();
    end
    expect_val("s5_right_len", 8'd8); expect_val("s5_left_en", 8'd0);
    expect_val("s5_dout", 8'hA);      expect_val("s5_fail", 8'd0);
    observe(8'(n)); observe(8'(nl)); observe(8'(dout)); observe(8'(fail_cnt));
    req = 2'b00; confirm = 2'b00; tick();

    // ---- async reset in the middle of OPEN ----
    do_reset();
    req = 2'b10; tick();
    confirm = 2'b10; pass_r = 4'b1010; tick();
    confirm = 2'b00; tick(); tick(); tick();
    expect_val("s6_open3", 8'd1);
    observe(8'(en_right));
    #2 rst = 1'b1;
    #1;
    expect_val("s6_rst_en", 8'd0);    expect_val("s6_rst_st", 8'd0);
    expect_val("s6_rst_grant", 8'd0); expect_val("s6_rst_dout", 8'd0);
    expect_val("s6_rst_misc", 8'd0);
    observe(8'({en_left, en_right})); observe(8'(state)); observe(8'(grant));
    observe(8'(dout)); observe(8'({locked, fail_cnt}));
    req = 2'b11; pass_l = 4'b1010;
    @(posedge clk); #1 rst = 1'b0;
    expect_val("s6_new_grant", 8'd1);
    tick(); observe(8'(grant));
    confirm = 2'b01; tick();
    confirm = 2'b00; req = 2'b00;
    expect_val("s6_new_len", 8'd8);
    tick(); count_high(0, n); observe(8'(n));

    // ---- wrap-up ----
    expect_val("invariants", 8'd0);
    observe(8'(illegal));
    check("sb_leftover", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
